// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: shared-RAM data-access stall FSM, load-use interlock, branch flush.
// Optional STALL_CNT_EN macro adds a saturating stall-cycle counter on stallcnt_o.
module pipe_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  regsrc1_i,
    input  logic [3:0]  regsrc2_i,
    input  logic        src1use_i,
    input  logic        src2use_i,
    input  logic [3:0]  exregdst_i,
    input  logic        exmemread_i,
    input  logic        memreq_i,
    input  logic        branch_i,
    output logic [4:0]  stall_o,
    output logic [1:0]  flush_o,
    output logic        ramsel_o,
    output logic [15:0] stallcnt_o
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SCNT_W = 16;
    localparam int unsigned STL_W  = 5;
    localparam int unsigned FLS_W  = 2;

    localparam bit               MULTI_CYC = (WAIT_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_INIT  = MULTI_CYC ? CNT_W'(WAIT_CYCLES - 2) : '0;

    localparam logic [STL_W-1:0] STALL_NONE = 5'b00000;
    localparam logic [STL_W-1:0] STALL_MEM  = 5'b01111;
    localparam logic [STL_W-1:0] STALL_LU   = 5'b00011;
    localparam logic [FLS_W-1:0] FLUSH_NONE = 2'b00;
    localparam logic [FLS_W-1:0] FLUSH_IFID = 2'b01;
    localparam logic [FLS_W-1:0] FLUSH_IDEX = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DACC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_memstall;
    logic             w_ramsel;
    logic             w_src1_hit;
    logic             w_src2_hit;
    logic             w_loaduse;

    // State and remaining-cycle counter; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Access sequencing: IDLE cycle with a request is access cycle 1; last cycle releases the stall.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_memstall  = 1'b0;
        w_ramsel    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (memreq_i) begin
                    w_ramsel = 1'b1;
                    if (MULTI_CYC) begin
                        w_memstall  = 1'b1;
                        w_state_nxt = ST_DACC;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_DACC: begin
                w_ramsel = 1'b1;
                if (r_cnt != '0) begin
                    w_memstall = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_src1_hit = src1use_i && (regsrc1_i == exregdst_i);
    assign w_src2_hit = src2use_i && (regsrc2_i == exregdst_i);
    assign w_loaduse  = exmemread_i && (w_src1_hit || w_src2_hit);

    // Hazard priority: memory stall over load-use over branch; losers are dropped since ID re-presents.
    always_comb begin
        stall_o  = STALL_NONE;
        flush_o  = FLUSH_NONE;
        ramsel_o = w_ramsel;
        if (w_memstall) begin
            stall_o = STALL_MEM;
        end else if (w_loaduse) begin
            stall_o = STALL_LU;
            flush_o = FLUSH_IDEX;
        end else if (branch_i) begin
            flush_o = FLUSH_IFID;
        end
    end

`ifdef STALL_CNT_EN
    logic [SCNT_W-1:0] r_stallcnt;

    // Counts cycles with the PC held, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallcnt <= '0;
        end else if (stall_o[0] && (r_stallcnt != {SCNT_W{1'b1}})) begin
            r_stallcnt <= r_stallcnt + SCNT_W'(1);
        end
    end

    assign stallcnt_o = r_stallcnt;
`else
    assign stallcnt_o = SCNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a negedge monitor pops and checks.
// Four instances cover WAIT_CYCLES = 3, 4, 1 and 6; each vector names the instance it checks.
module tb_pipe_ctrl;

    localparam logic [1:0] D_W3 = 2'd0;
    localparam logic [1:0] D_W4 = 2'd1;
    localparam logic [1:0] D_W1 = 2'd2;
    localparam logic [1:0] D_W6 = 2'd3;

`ifdef STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [1:0]  which;
        logic [4:0]  stall;
        logic [1:0]  flush;
        logic        ramsel;
        bit          chk_cnt;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  regsrc1_i = '0;
    logic [3:0]  regsrc2_i = '0;
    logic        src1use_i = 1'b0;
    logic        src2use_i = 1'b0;
    logic [3:0]  exregdst_i = '0;
    logic        exmemread_i = 1'b0;
    logic [3:0]  memreq = '0;
    logic        branch_i = 1'b0;

    logic [4:0]  stall [4];
    logic [1:0]  flush [4];
    logic        ramsel [4];
    logic [15:0] scnt [4];

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .regsrc1_i(regsrc1_i), .regsrc2_i(regsrc2_i),
        .src1use_i(src1use_i), .src2use_i(src2use_i), .exregdst_i(exregdst_i),
        .exmemread_i(exmemread_i), .memreq_i(memreq[0]), .branch_i(branch_i),
        .stall_o(stall[0]), .flush_o(flush[0]), .ramsel_o(ramsel[0]), .stallcnt_o(scnt[0]));

    pipe_ctrl #(.WAIT_CYCLES(4)) u_w4 (
        .clk(clk), .rst(rst), .regsrc1_i(regsrc1_i), .regsrc2_i(regsrc2_i),
        .src1use_i(src1use_i), .src2use_i(src2use_i), .exregdst_i(exregdst_i),
        .exmemread_i(exmemread_i), .memreq_i(memreq[1]), .branch_i(branch_i),
        .stall_o(stall[1]), .flush_o(flush[1]), .ramsel_o(ramsel[1]), .stallcnt_o(scnt[1]));

    pipe_ctrl #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .regsrc1_i(regsrc1_i), .regsrc2_i(regsrc2_i),
        .src1use_i(src1use_i), .src2use_i(src2use_i), .exregdst_i(exregdst_i),
        .exmemread_i(exmemread_i), .memreq_i(memreq[2]), .branch_i(branch_i),
        .stall_o(stall[2]), .flush_o(flush[2]), .ramsel_o(ramsel[2]), .stallcnt_o(scnt[2]));

    pipe_ctrl #(.WAIT_CYCLES(6)) u_w6 (
        .clk(clk), .rst(rst), .regsrc1_i(regsrc1_i), .regsrc2_i(regsrc2_i),
        .src1use_i(src1use_i), .src2use_i(src2use_i), .exregdst_i(exregdst_i),
        .exmemread_i(exmemread_i), .memreq_i(memreq[3]), .branch_i(branch_i),
        .stall_o(stall[3]), .flush_o(flush[3]), .ramsel_o(ramsel[3]), .stallcnt_o(scnt[3]));

    // Drive one cycle of inputs and queue the expected response of the selected instance.
    task automatic apply(input string nm, input logic [1:0] w, input logic rs, input logic mr,
                         input logic br, input logic exmr, input logic [3:0] exd,
                         input logic [3:0] s1, input logic s1u, input logic [3:0] s2, input logic s2u,
                         input logic [4:0] es, input logic [1:0] ef, input logic er,
                         input bit cc, input logic [15:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = rs;
        memreq      = '0;
        memreq[w]   = mr;
        branch_i    = br;
        exmemread_i = exmr;
        exregdst_i  = exd;
        regsrc1_i   = s1;
        src1use_i   = s1u;
        regsrc2_i   = s2;
        src2use_i   = s2u;
        e.name    = nm;
        e.which   = w;
        e.stall   = es;
        e.flush   = ef;
        e.ramsel  = er;
        e.chk_cnt = cc;
        e.cnt     = ec;
        q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle with a queued vector is checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if ({stall[e.which], flush[e.which], ramsel[e.which]} !== {e.stall, e.flush, e.ramsel}) begin
                n_err++;
                $display("FAIL %s: got stall=%b flush=%b ramsel=%b, expected stall=%b flush=%b ramsel=%b",
                         e.name, stall[e.which], flush[e.which], ramsel[e.which],
                         e.stall, e.flush, e.ramsel);
            end
            if (e.chk_cnt) begin
                n_vec++;
                if (scnt[e.which] !== e.cnt) begin
                    n_err++;
                    $display("FAIL %s_cnt: got stallcnt=%0d, expected %0d", e.name, scnt[e.which], e.cnt);
                end
            end
        end
    end

    initial begin
        // name          dut   rs  mr  br  exmr exd    s1     s1u s2     s2u stall     flush  rs  cc  cnt
        apply("rst_idle",  D_W3, 0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 1, 16'd0);
        apply("idle",      D_W3, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);

        // WAIT_CYCLES=3 access with memreq held three cycles
        apply("w3_k1",     D_W3, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w3_k2",     D_W3, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w3_k3",     D_W3, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 1, 0, 16'd0);
        apply("w3_after",  D_W3, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);

        // memory stall masks load-use and branch; load-use appears on the release cycle
        apply("w3_pri_k1", D_W3, 1, 1, 1, 1, 4'h5, 4'h5, 1, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w3_pri_k2", D_W3, 1, 0, 1, 1, 4'h5, 4'h5, 1, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w3_pri_k3", D_W3, 1, 0, 1, 1, 4'h5, 4'h5, 1, 4'h0, 0, 5'b00011, 2'b10, 1, 0, 16'd0);
        apply("w3_pri_lu", D_W3, 1, 0, 1, 1, 4'h5, 4'h5, 1, 4'h0, 0, 5'b00011, 2'b10, 0, 0, 16'd0);

        // load-use detection
        apply("lu_src1",   D_W3, 1, 0, 0, 1, 4'h5, 4'h5, 1, 4'h0, 0, 5'b00011, 2'b10, 0, 0, 16'd0);
        apply("lu_nouse",  D_W3, 1, 0, 0, 1, 4'h5, 4'h5, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);
        apply("lu_src2",   D_W3, 1, 0, 0, 1, 4'hF, 4'h0, 1, 4'hF, 1, 5'b00011, 2'b10, 0, 0, 16'd0);
        apply("lu_src2nu", D_W3, 1, 0, 0, 1, 4'hF, 4'h0, 1, 4'hF, 0, 5'b00000, 2'b00, 0, 0, 16'd0);
        apply("lu_reg0",   D_W3, 1, 0, 0, 1, 4'h0, 4'h0, 1, 4'h7, 0, 5'b00011, 2'b10, 0, 0, 16'd0);
        apply("lu_noload", D_W3, 1, 0, 0, 0, 4'h5, 4'h5, 1, 4'h5, 1, 5'b00000, 2'b00, 0, 0, 16'd0);
        apply("lu_diff",   D_W3, 1, 0, 0, 1, 4'h3, 4'h2, 1, 4'h4, 1, 5'b00000, 2'b00, 0, 0, 16'd0);

        // branch flush and its suppression by load-use
        apply("br_lu",     D_W3, 1, 0, 1, 1, 4'h5, 4'h5, 1, 4'h0, 0, 5'b00011, 2'b10, 0, 0, 16'd0);
        apply("br_only",   D_W3, 1, 0, 1, 0, 4'h5, 4'h5, 1, 4'h0, 0, 5'b00000, 2'b01, 0, 0, 16'd0);
        apply("quiet",     D_W3, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);

        // WAIT_CYCLES=4 access abandoned by reset, then a full access
        apply("w4_k1",     D_W4, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w4_rst",    D_W4, 0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);
        apply("w4_idle",   D_W4, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);
        apply("w4_k1b",    D_W4, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w4_k2b",    D_W4, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w4_k3b",    D_W4, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w4_k4b",    D_W4, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 1, 0, 16'd0);
        apply("w4_done",   D_W4, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);

        // WAIT_CYCLES=1: single-cycle access, never stalls
        apply("w1_req",    D_W1, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 1, 0, 16'd0);
        apply("w1_req2",   D_W1, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 1, 0, 16'd0);
        apply("w1_off",    D_W1, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 0, 16'd0);
        apply("w1_req_lu", D_W1, 1, 1, 0, 1, 4'h9, 4'h0, 0, 4'h9, 1, 5'b00011, 2'b10, 1, 0, 16'd0);

        // WAIT_CYCLES=6: five memory-stall cycles then one load-use cycle
        apply("cnt_rst",   D_W6, 0, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 1, 16'd0);
        apply("w6_k1",     D_W6, 1, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 1, 16'd0);
        apply("w6_k2",     D_W6, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w6_k3",     D_W6, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w6_k4",     D_W6, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w6_k5",     D_W6, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b01111, 2'b00, 1, 0, 16'd0);
        apply("w6_k6",     D_W6, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 1, 1,
              CNT_ON ? 16'd5 : 16'd0);
        apply("w6_lu",     D_W6, 1, 0, 0, 1, 4'hA, 4'hA, 1, 4'h0, 0, 5'b00011, 2'b10, 0, 0, 16'd0);
        apply("w6_cnt",    D_W6, 1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0, 5'b00000, 2'b00, 0, 1,
              CNT_ON ? 16'd6 : 16'd0);

        // let the monitor drain, bounded
        for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, legal 1..8: shared-RAM data-access length in cycles.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port regsrc1_i / regsrc2_i  input  4 each  ID-stage source register numbers.
REQ-005 SHALL provide port src1use_i / src2use_i  input  1 each  ID instruction actually reads the corresponding source.
REQ-006 SHALL provide port exregdst_i  input  4  EX-stage destination register.
REQ-007 SHALL provide port exmemread_i  input  1  EX-stage instruction is a load.
REQ-008 SHALL provide port memreq_i  input  1  MEM-stage instruction needs the shared RAM (load or store).
REQ-009 SHALL provide port branch_i  input  1  ID resolved a taken branch or jump.
REQ-010 SHALL provide port stall_o  output  5  hold bits: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB.
REQ-011 SHALL provide port flush_o  output  2  bubble insert: [0] IF/ID, [1] ID/EX.
REQ-012 SHALL provide port ramsel_o  output  1  shared-RAM owner: 0 = instruction fetch, 1 = MEM stage.
REQ-013 SHALL provide port stallcnt_o  output  16  stall-cycle counter (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE and DACC plus a 3-bit remaining-cycle counter cnt.
REQ-015 Access cycle k=1 is the IDLE cycle where memreq_i=1; the access spans k=1..WAIT_CYCLES.
REQ-016 IDLE with memreq_i=1 and WAIT_CYCLES>1: stall_o=5'b01111, ramsel_o=1, next state DACC, cnt<=WAIT_CYCLES-2.
REQ-017 IDLE with memreq_i=1 and WAIT_CYCLES=1: ramsel_o=1, no memory stall, state stays IDLE.
REQ-018 DACC with cnt!=0: stall_o=5'b01111, ramsel_o=1, cnt decrements.
REQ-019 DACC with cnt=0: memory stall released, ramsel_o=1, next state IDLE; memreq_i ignored this cycle.
REQ-020 ramsel_o SHALL be 0 in every cycle not covered by REQ-016..REQ-019.
REQ-021 Load-use hazard = exmemread_i & ((src1use_i & regsrc1_i==exregdst_i) | (src2use_i & regsrc2_i==exregdst_i)); all 16 register codes compared, none exempt.
REQ-022 Load-use without memory stall: stall_o=5'b00011, flush_o[1]=1 for that cycle.
REQ-023 branch_i without memory stall or load-use: flush_o[0]=1; stall_o=0.
REQ-024 Priority SHALL be memory stall > load-use > branch flush; lower-priority actions are suppressed, not queued (ID holds, so its inputs re-present).
REQ-025 stall_o, flush_o, ramsel_o SHALL be combinational from state, cnt and inputs (zero-cycle latency).
REQ-026 With no hazard: stall_o=0, flush_o=0.

Reset
REQ-027 rst low SHALL immediately force state IDLE, cnt=0, stallcnt_o=0; outputs then follow REQ-020/REQ-026 from inputs.
REQ-028 Reset asserted mid-access SHALL abandon the access; the first post-reset memreq_i starts a new access at k=1.

Configuration
REQ-029 Macro STALL_CNT_EN defined: stallcnt_o increments each cycle stall_o[0]=1, saturates at 16'hFFFF, cleared only by reset.
REQ-030 Macro STALL_CNT_EN undefined: no counter logic; stallcnt_o tied to 16'h0000; port remains.

Verification
REQ-031 WAIT_CYCLES=3, memreq_i pulse held 3 cycles -> stall_o=01111,01111,00000; ramsel_o=1,1,1; then 0.
REQ-032 exmemread_i=1, exregdst_i=4'b0101, regsrc1_i=4'b0101, src1use_i=1 -> stall_o=00011, flush_o=10; src1use_i=0 -> both 0.
REQ-033 branch_i=1 and load-use same cycle -> flush_o=10 only; branch_i alone next cycle -> flush_o=01.
REQ-034 WAIT_CYCLES=4, rst low at access cycle 2 -> state IDLE, stall_o=0 while memreq_i=0; new memreq_i gives full 4-cycle access.
REQ-035 STALL_CNT_EN, 5 memory-stall cycles + 1 load-use cycle -> stallcnt_o=16'd6; without macro -> 16'd0.
REQ-036 WAIT_CYCLES=1, memreq_i=1 -> stall_o=0, ramsel_o=1 same cycle, FSM stays IDLE.
